// File: rtl/exe_muldiv_seq.sv
// Multi-cycle RV32M multiply/divide sequencer for the EXE stage.
// Radix-2 shift-add multiply, restoring divide, and single-cycle fast paths for the divide corner cases.
module exe_muldiv_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [2:0]       funct3_i,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StMul  = 2'd1;
  localparam logic [1:0] StDiv  = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [2:0]         f3_q, f3_d;
  logic               neg_q, neg_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [2*WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   result_q, result_d;

  logic               accept, is_div, a_sgn, b_sgn, a_neg, b_neg, div_zero, div_ovf;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_upper, div_trial;
  logic [2*WIDTH:0]   mul_next, div_shift, div_next;
  logic [2*WIDTH-1:0] mul_prod;
  logic [WIDTH-1:0]   div_raw, calc;

  assign accept = (state_q == StIdle) & start_i & ~flush_i;
  assign is_div = funct3_i[2];
  assign a_sgn  = is_div ? ~funct3_i[0] : (funct3_i[1:0] == 2'b01 || funct3_i[1:0] == 2'b10);
  assign b_sgn  = is_div ? ~funct3_i[0] : (funct3_i[1:0] == 2'b01);
  assign a_neg  = a_sgn & op_a_i[WIDTH-1];
  assign b_neg  = b_sgn & op_b_i[WIDTH-1];
  assign mag_a  = a_neg ? -op_a_i : op_a_i;
  assign mag_b  = b_neg ? -op_b_i : op_b_i;

  assign div_zero = (op_b_i == '0);
  assign div_ovf  = ~funct3_i[0] & (op_a_i == {1'b1, {(WIDTH-1){1'b0}}}) & (op_b_i == '1);

  // Multiply: multiplier sits in the low half and is consumed LSB first.
  assign mul_upper = acc_q[2*WIDTH:WIDTH] + (acc_q[0] ? {1'b0, opb_q} : '0);
  assign mul_next  = {1'b0, mul_upper, acc_q[WIDTH-1:1]};

  // Divide: {remainder, quotient} shifts left; quotient bits enter at the LSB.
  assign div_shift = {acc_q[2*WIDTH-1:0], 1'b0};
  assign div_trial = div_shift[2*WIDTH:WIDTH] - {1'b0, opb_q};
  assign div_next  = (div_shift[2*WIDTH:WIDTH] >= {1'b0, opb_q}) ?
                     {div_trial, div_shift[WIDTH-1:1], 1'b1} : div_shift;

  always_comb begin
    mul_prod = neg_q ? -acc_q[2*WIDTH-1:0] : acc_q[2*WIDTH-1:0];
    div_raw  = f3_q[1] ? acc_q[2*WIDTH-1:WIDTH] : acc_q[WIDTH-1:0];
    if (f3_q[2]) begin
      calc = neg_q ? -div_raw : div_raw;
    end else begin
      calc = (f3_q[1:0] == 2'b00) ? mul_prod[WIDTH-1:0] : mul_prod[2*WIDTH-1:WIDTH];
    end
  end

  assign stall_o  = accept | (((state_q == StMul) | (state_q == StDiv)) & ~flush_i);
  assign done_o   = (state_q == StDone) & ~flush_i;
  assign result_o = done_o ? calc : result_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    f3_d     = f3_q;
    neg_d    = neg_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    result_d = result_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          f3_d  = funct3_i;
          cnt_d = '0;
          if (is_div) begin
            neg_d = funct3_i[1] ? a_neg : (a_neg ^ b_neg);
            opb_d = mag_b;
            if (div_zero) begin
              // Fast-path results are parked in acc so the DONE mux needs no special case.
              acc_d   = {1'b0, op_a_i, {WIDTH{1'b1}}};
              neg_d   = 1'b0;
              state_d = StDone;
            end else if (div_ovf) begin
              acc_d   = {{(WIDTH+1){1'b0}}, op_a_i};
              neg_d   = 1'b0;
              state_d = StDone;
            end else begin
              acc_d   = {{(WIDTH+1){1'b0}}, mag_a};
              state_d = StDiv;
            end
          end else begin
            neg_d   = a_neg ^ b_neg;
            opb_d   = mag_a;
            acc_d   = {{(WIDTH+1){1'b0}}, mag_b};
            state_d = StMul;
          end
        end
      end
      StMul, StDiv: begin
        if (flush_i) begin
          state_d = StIdle;
        end else begin
          acc_d = (state_q == StMul) ? mul_next : div_next;
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == CntW'(WIDTH - 1)) state_d = StDone;
        end
      end
      default: begin
        state_d = StIdle;
        if (!flush_i) result_d = calc;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      f3_q     <= '0;
      neg_q    <= 1'b0;
      opb_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      f3_q     <= f3_d;
      neg_q    <= neg_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_exe_muldiv_seq.sv
// Directed bench for exe_muldiv_seq: hand-computed RV32M vectors, latency, flush and reset checks.
module tb_exe_muldiv_seq;

  localparam logic [2:0] F_MUL = 3'b000, F_MULH = 3'b001, F_MULHSU = 3'b010, F_MULHU = 3'b011;
  localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic [2:0]  funct3_i = '0;
  logic [31:0] op_a_i = '0;
  logic [31:0] op_b_i = '0;
  logic        flush_i = 1'b0;
  logic        stall_o, done_o;
  logic [31:0] result_o;

  int vec_cnt = 0;
  int miscompares = 0;
  logic [31:0] last_res = '0;

  exe_muldiv_seq #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start_i),
    .funct3_i (funct3_i),
    .op_a_i   (op_a_i),
    .op_b_i   (op_b_i),
    .flush_i  (flush_i),
    .stall_o  (stall_o),
    .done_o   (done_o),
    .result_o (result_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Called just after a rising edge; drives cycle T and leaves us in T+1.
  task automatic start_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input string tag);
    start_i = 1'b1; funct3_i = f3; op_a_i = a; op_b_i = b;
    @(negedge clk);
    chk({tag, " stall@T"}, {31'b0, stall_o}, 32'd1);
    @(posedge clk);
    #1 start_i = 1'b0;
  endtask

  task automatic wait_done(input int lat, input logic [31:0] exp, input string tag);
    int k;
    bit stall_bad;
    k = 0;
    stall_bad = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      k = i;
      if (done_o) break;
      if (!stall_o) stall_bad = 1'b1;
    end
    chk({tag, " latency"}, k, lat);
    chk({tag, " result"}, result_o, exp);
    chk({tag, " stall-while-busy"}, {31'b0, stall_bad}, 32'd0);
    chk({tag, " stall@done"}, {31'b0, stall_o}, 32'd0);
    @(negedge clk);
    chk({tag, " done-pulse"}, {31'b0, done_o}, 32'd0);
    chk({tag, " result-hold"}, result_o, exp);
    last_res = exp;
  endtask

  task automatic run(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                     input int lat, input logic [31:0] exp, input string tag);
    @(posedge clk);
    #1;
    start_op(f3, a, b, tag);
    wait_done(lat, exp, tag);
  endtask

  initial begin
    #12;
    chk("reset stall", {31'b0, stall_o}, 32'd0);
    chk("reset done", {31'b0, done_o}, 32'd0);
    chk("reset result", result_o, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    run(F_MUL,    32'd7,        32'hFFFFFFFD, 33, 32'hFFFFFFEB, "mul 7*-3");
    run(F_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 33, 32'hFFFFFFFE, "mulhu ff*ff");
    run(F_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 33, 32'h00000000, "mulh -1*-1");
    run(F_MULHSU, 32'hFFFFFFFF, 32'd2,        33, 32'hFFFFFFFF, "mulhsu -1*2");
    run(F_MULH,   32'h80000000, 32'h80000000, 33, 32'h40000000, "mulh min*min");
    run(F_DIV,    32'h80000000, 32'hFFFFFFFF, 1,  32'h80000000, "div ovf");
    run(F_REM,    32'h80000000, 32'hFFFFFFFF, 1,  32'h00000000, "rem ovf");
    run(F_DIVU,   32'd5,        32'd0,        1,  32'hFFFFFFFF, "divu 5/0");
    run(F_REMU,   32'd5,        32'd0,        1,  32'd5,        "remu 5/0");
    run(F_REM,    32'hFFFFFFFB, 32'd0,        1,  32'hFFFFFFFB, "rem -5/0");
    run(F_REM,    32'hFFFFFFF9, 32'd2,        33, 32'hFFFFFFFF, "rem -7%2");
    run(F_DIV,    32'hFFFFFFF9, 32'd2,        33, 32'hFFFFFFFD, "div -7/2");
    run(F_DIVU,   32'd100,      32'd7,        33, 32'd14,       "divu 100/7");
    run(F_REMU,   32'd100,      32'd7,        33, 32'd2,        "remu 100/7");

    // start and flush in the same cycle: not accepted
    @(posedge clk);
    #1 start_i = 1'b1; flush_i = 1'b1; funct3_i = F_MUL; op_a_i = 32'd3; op_b_i = 32'd5;
    @(negedge clk);
    chk("start+flush stall", {31'b0, stall_o}, 32'd0);
    @(posedge clk);
    #1 start_i = 1'b0; flush_i = 1'b0;
    @(negedge clk);
    chk("start+flush idle stall", {31'b0, stall_o}, 32'd0);
    chk("start+flush done", {31'b0, done_o}, 32'd0);

    // flush at T+10 of a divide, new multiply accepted at T+11
    @(posedge clk);
    #1;
    start_op(F_DIV, 32'd100, 32'd7, "flush div");
    repeat (9) @(posedge clk);
    #1 flush_i = 1'b1;
    @(negedge clk);
    chk("flush stall", {31'b0, stall_o}, 32'd0);
    chk("flush done", {31'b0, done_o}, 32'd0);
    chk("flush result kept", result_o, last_res);
    @(posedge clk);
    #1 flush_i = 1'b0;
    start_op(F_MUL, 32'd3, 32'd5, "mul after flush");
    wait_done(33, 32'd15, "mul after flush");

    // reset at T+5 of a multiply
    @(posedge clk);
    #1;
    start_op(F_MUL, 32'd7, 32'd9, "mul reset");
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midop reset stall", {31'b0, stall_o}, 32'd0);
    chk("midop reset done", {31'b0, done_o}, 32'd0);
    chk("midop reset result", result_o, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    run(F_MUL, 32'd7, 32'd9, 33, 32'd63, "mul post-reset");

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
    $finish;
  end

endmodule
